// File: rtl/pusha_popa_sequencer_pkg.sv
// Shared state encoding and GPR index map for the PUSHA/POPA sequencer.
package pusha_popa_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_SP,
        S_CAPTURE_SP,
        S_FETCH,
        S_STORE,
        S_POP,
        S_WRITE_SP,
        S_DONE
    } state_t;

    localparam logic [2:0] AX_IDX = 3'd0;
    localparam logic [2:0] CX_IDX = 3'd1;
    localparam logic [2:0] DX_IDX = 3'd2;
    localparam logic [2:0] BX_IDX = 3'd3;
    localparam logic [2:0] SP_IDX = 3'd4;
    localparam logic [2:0] BP_IDX = 3'd5;
    localparam logic [2:0] SI_IDX = 3'd6;
    localparam logic [2:0] DI_IDX = 3'd7;

    localparam logic [15:0] WORD_BYTES = 16'd2;

endpackage

// File: rtl/pusha_popa_sequencer.sv
// PUSHA/POPA micro-sequencer over a 1-cycle-latency GPR port; zero-wait PUSHA 19 / POPA 12 cycles.
// Each stack access stalls in place (address/data held) until mem_ack; ack is accepted combinationally.
module pusha_popa_sequencer
    import pusha_popa_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_pop,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rf_rd_sel,
    input  logic [15:0] rf_rd_val,
    output logic [2:0]  rf_wr_sel,
    output logic [15:0] rf_wr_val,
    output logic        rf_wr_en,
    output logic        rf_is_8_bit,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wr_data,
    input  logic        mem_ack,
    input  logic [15:0] mem_rd_data
);

    state_t      r_state;
    logic        r_is_pop;
    logic [2:0]  r_idx;
    logic [15:0] r_sp_ptr;
    logic [15:0] r_sp_orig;

    state_t      w_state_nxt;
    logic        w_is_pop_nxt;
    logic [2:0]  w_idx_nxt;
    logic [15:0] w_sp_ptr_nxt;
    logic [15:0] w_sp_orig_nxt;
    logic        w_rf_wr_en;
    logic        w_mem_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_is_pop  <= 1'b0;
            r_idx     <= 3'd0;
            r_sp_ptr  <= 16'd0;
            r_sp_orig <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_is_pop  <= w_is_pop_nxt;
            r_idx     <= w_idx_nxt;
            r_sp_ptr  <= w_sp_ptr_nxt;
            r_sp_orig <= w_sp_orig_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_is_pop_nxt  = r_is_pop;
        w_idx_nxt     = r_idx;
        w_sp_ptr_nxt  = r_sp_ptr;
        w_sp_orig_nxt = r_sp_orig;
        w_rf_wr_en    = 1'b0;
        w_mem_req     = 1'b0;
        done          = 1'b0;
        rf_rd_sel     = 3'd0;
        rf_wr_sel     = 3'd0;
        rf_wr_val     = 16'd0;
        mem_wr        = 1'b0;
        mem_addr      = 16'd0;
        mem_wr_data   = 16'd0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_LOAD_SP;
                    w_is_pop_nxt = is_pop;
                end
            end
            S_LOAD_SP: begin
                rf_rd_sel   = SP_IDX;
                w_state_nxt = S_CAPTURE_SP;
            end
            S_CAPTURE_SP: begin
                w_sp_orig_nxt = rf_rd_val;
                w_sp_ptr_nxt  = rf_rd_val;
                if (r_is_pop) begin
                    w_idx_nxt   = DI_IDX;
                    w_state_nxt = S_POP;
                end else begin
                    w_idx_nxt   = AX_IDX;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                rf_rd_sel   = r_idx;
                w_state_nxt = S_STORE;
            end
            S_STORE: begin
                // Keep the read select on idx so rf_rd_val stays stable across wait states.
                rf_rd_sel   = r_idx;
                w_mem_req   = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = r_sp_ptr - WORD_BYTES;
                mem_wr_data = (r_idx == SP_IDX) ? r_sp_orig : rf_rd_val;
                if (mem_ack) begin
                    w_sp_ptr_nxt = r_sp_ptr - WORD_BYTES;
                    w_idx_nxt    = r_idx + 3'd1;
                    if (r_idx == DI_IDX) begin
                        w_state_nxt = S_WRITE_SP;
                    end else if ((r_idx + 3'd1) == SP_IDX) begin
                        w_state_nxt = S_STORE;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_POP: begin
                w_mem_req = 1'b1;
                mem_addr  = r_sp_ptr;
                if (mem_ack) begin
                    // The stacked SP slot is skipped; SP is rebuilt from the pointer instead.
                    if (r_idx != SP_IDX) begin
                        w_rf_wr_en = 1'b1;
                        rf_wr_sel  = r_idx;
                        rf_wr_val  = mem_rd_data;
                    end
                    w_sp_ptr_nxt = r_sp_ptr + WORD_BYTES;
                    w_idx_nxt    = r_idx - 3'd1;
                    if (r_idx == AX_IDX) begin
                        w_state_nxt = S_WRITE_SP;
                    end
                end
            end
            S_WRITE_SP: begin
                w_rf_wr_en  = 1'b1;
                rf_wr_sel   = SP_IDX;
                rf_wr_val   = r_sp_ptr;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset aborts immediately, so no request or write may escape in the reset cycle itself.
    assign rf_wr_en    = w_rf_wr_en & ~reset;
    assign mem_req     = w_mem_req & ~reset;
    assign busy        = (r_state != S_IDLE);
    assign rf_is_8_bit = 1'b0;

endmodule

// File: tb/tb_pusha_popa_sequencer.sv
// Bench for pusha_popa_sequencer: GPR file and stack memory models plus a stack-semantics reference.
module tb_pusha_popa_sequencer;
    import pusha_popa_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, is_pop;
    logic        busy, done, rf_wr_en, rf_is_8_bit, mem_req, mem_wr, mem_ack;
    logic [2:0]  rf_rd_sel, rf_wr_sel;
    logic [15:0] rf_rd_val, rf_wr_val, mem_addr, mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    pusha_popa_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_pop(is_pop),
        .busy(busy), .done(done),
        .rf_rd_sel(rf_rd_sel), .rf_rd_val(rf_rd_val),
        .rf_wr_sel(rf_wr_sel), .rf_wr_val(rf_wr_val), .rf_wr_en(rf_wr_en),
        .rf_is_8_bit(rf_is_8_bit),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
    );

    typedef struct packed { logic [15:0] a; logic [15:0] d; } rec_t;

    logic [15:0] gpr      [8];
    logic [15:0] gpr_init [8];
    logic [15:0] orig_regs[8];
    logic [15:0] stack_mem[65536];
    logic        gpr_load  = 1'b0;
    logic        ack_force = 1'b0;
    rec_t        mem_log[$];
    rec_t        rf_log[$];
    int          wait_mode = 0;
    int          wait_cnt = 0, wait_target = 0, wait_sum = 0;
    int          ack_count = 0, done_count = 0;
    int          passed = 0, total = 0;
    logic [15:0] wait_sp;

    function automatic int pick_wait(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    assign mem_ack     = ack_force | (mem_req & (wait_cnt >= wait_target));
    assign mem_rd_data = stack_mem[mem_addr];

    always @(posedge clk) begin
        rf_rd_val <= gpr[rf_rd_sel];
        if (gpr_load) begin
            for (int i = 0; i < 8; i++) gpr[i] <= gpr_init[i];
        end else if (rf_wr_en) begin
            gpr[rf_wr_sel] <= rf_wr_val;
            rf_log.push_back(rec_t'{a: 16'(rf_wr_sel), d: rf_wr_val});
        end
        if (mem_req && mem_ack) begin
            ack_count <= ack_count + 1;
            wait_sum  <= wait_sum + wait_target;
            if (mem_wr) begin
                stack_mem[mem_addr] <= mem_wr_data;
                mem_log.push_back(rec_t'{a: mem_addr, d: mem_wr_data});
            end
            wait_cnt    <= 0;
            wait_target <= pick_wait(wait_mode);
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt    <= 0;
            wait_target <= pick_wait(wait_mode);
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic load_gprs();
        @(negedge clk) gpr_load = 1'b1;
        @(negedge clk) gpr_load = 1'b0;
    endtask

    task automatic random_regs(input logic [15:0] sp);
        for (int i = 0; i < 8; i++) gpr_init[i] = 16'($urandom);
        gpr_init[SP_IDX] = sp;
        for (int i = 0; i < 8; i++) orig_regs[i] = gpr_init[i];
    endtask

    // Start one operation and count cycles until done; a start glitch can be injected mid-run.
    task automatic run_op(input logic op, input int glitch_at, output int cyc, output bit to, output int waits);
        int ws0;
        ws0 = wait_sum;
        mem_log.delete();
        rf_log.delete();
        @(negedge clk);
        start = 1'b1; is_pop = op;
        @(negedge clk);
        start = 1'b0; is_pop = ~op;
        cyc = 1; to = 1'b0;
        while (done !== 1'b1) begin
            if (cyc == glitch_at) begin start = 1'b1; is_pop = ~op; end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc > 600) begin to = 1'b1; break; end
        end
        start = 1'b0;
        waits = wait_sum - ws0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; is_pop = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, mem_req, mem_wr, rf_wr_en, rf_is_8_bit} !== 6'b0 ||
            {rf_rd_sel, rf_wr_sel} !== 6'b0 || {mem_addr, mem_wr_data} !== 32'b0) begin
            $display("FAIL reset_outputs: busy=%b done=%b req=%b wr=%b wen=%b rd=%0d ws=%0d addr=%h wd=%h, want all 0",
                     busy, done, mem_req, mem_wr, rf_wr_en, rf_rd_sel, rf_wr_sel, mem_addr, mem_wr_data);
        end else passed++;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_beats_start: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_pusha_directed();
        int cyc, ws; bit to; logic [15:0] ea, ed;
        for (int i = 0; i < 8; i++) gpr_init[i] = 16'(16'h1111 * (i + 1));
        gpr_init[SP_IDX] = 16'h0100;
        for (int i = 0; i < 8; i++) orig_regs[i] = gpr_init[i];
        load_gprs();
        run_op(1'b0, 0, cyc, to, ws);
        total++;
        if (to || cyc != 19) $display("FAIL push_latency: got %0d (timeout=%0d) want 19", cyc, to);
        else passed++;
        total++;
        if (mem_log.size() != 8) $display("FAIL push_count: got %0d want 8", mem_log.size());
        else passed++;
        for (int i = 0; i < 8 && i < mem_log.size(); i++) begin
            ea = 16'h0100 - 16'(2 * (i + 1));
            ed = (i == 4) ? 16'h0100 : orig_regs[i];
            total++;
            if (mem_log[i].a !== ea || mem_log[i].d !== ed)
                $display("FAIL push_wr[%0d]: got %h=%h want %h=%h", i, mem_log[i].a, mem_log[i].d, ea, ed);
            else passed++;
        end
        total++;
        if (rf_log.size() != 1 || rf_log[0] !== rec_t'{a: 16'd4, d: 16'h00F0})
            $display("FAIL push_sp_write: got %0d writes first %h want 1 write 0004=00F0", rf_log.size(), rf_log[0]);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
        else passed++;
    endtask

    task automatic test_popa_directed();
        int cyc, ws, errs; bit to;
        int order[7] = '{7, 6, 5, 3, 2, 1, 0};
        for (int i = 0; i < 8; i++) gpr_init[i] = 16'hDEAD;
        gpr_init[SP_IDX] = 16'h00F0;
        load_gprs();
        run_op(1'b1, 0, cyc, to, ws);
        total++;
        if (to || cyc != 12) $display("FAIL pop_latency: got %0d (timeout=%0d) want 12", cyc, to);
        else passed++;
        total++;
        if (rf_log.size() != 8) $display("FAIL pop_count: got %0d want 8", rf_log.size());
        else passed++;
        for (int k = 0; k < 7 && k < rf_log.size(); k++) begin
            total++;
            if (rf_log[k].a !== 16'(order[k]) || rf_log[k].d !== orig_regs[order[k]])
                $display("FAIL pop_wr[%0d]: got r%0d=%h want r%0d=%h", k, rf_log[k].a, rf_log[k].d,
                         order[k], orig_regs[order[k]]);
            else passed++;
        end
        errs = 0;
        for (int i = 0; i < 8; i++) if (i != 4 && gpr[i] !== orig_regs[i]) errs++;
        total++;
        if (errs != 0 || gpr[SP_IDX] !== 16'h0100)
            $display("FAIL pop_regs: %0d bad regs, SP=%h want 0 bad, SP=0100", errs, gpr[SP_IDX]);
        else passed++;
    endtask

    task automatic test_wrap();
        int cyc, ws, errs; bit to; logic [15:0] ea, ed;
        random_regs(16'h0004);
        load_gprs();
        run_op(1'b0, 0, cyc, to, ws);
        errs = (mem_log.size() == 8) ? 0 : 1;
        for (int i = 0; i < 8 && i < mem_log.size(); i++) begin
            ea = 16'h0004 - 16'(2 * (i + 1));
            ed = (i == 4) ? 16'h0004 : orig_regs[i];
            if (mem_log[i].a !== ea || mem_log[i].d !== ed) errs++;
        end
        total++;
        if (to || errs != 0) $display("FAIL wrap_writes: %0d bad (timeout=%0d) want 0", errs, to);
        else passed++;
        total++;
        if (gpr[SP_IDX] !== 16'hFFF4) $display("FAIL wrap_sp: got %h want FFF4", gpr[SP_IDX]);
        else passed++;
    endtask

    task automatic test_wait_states();
        int cyc, errs; bit pend; logic [15:0] pa, pd, ea, ed;
        wait_sp = 16'($urandom) | 16'h0100;
        random_regs(wait_sp);
        load_gprs();
        wait_mode = 1;
        mem_log.delete();
        rf_log.delete();
        @(negedge clk);
        start = 1'b1; is_pop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; pend = 1'b0; pa = '0; pd = '0;
        while (done !== 1'b1 && cyc <= 600) begin
            if (pend) begin
                total++;
                if (mem_req !== 1'b1 || mem_addr !== pa || mem_wr_data !== pd)
                    $display("FAIL wait_hold: req=%b %h=%h want 1 %h=%h", mem_req, mem_addr, mem_wr_data, pa, pd);
                else passed++;
            end
            pend = mem_req && !mem_ack;
            pa = mem_addr; pd = mem_wr_data;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != 19 + 24) $display("FAIL wait_latency: got %0d want 43", cyc);
        else passed++;
        errs = (mem_log.size() == 8) ? 0 : 1;
        for (int i = 0; i < 8 && i < mem_log.size(); i++) begin
            ea = wait_sp - 16'(2 * (i + 1));
            ed = (i == 4) ? wait_sp : orig_regs[i];
            if (mem_log[i].a !== ea || mem_log[i].d !== ed) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL wait_writes: %0d bad want 0", errs);
        else passed++;
        wait_mode = 0;
    endtask

    task automatic test_reset_mid_pop();
        int a0, n, viol; logic [15:0] sp;
        sp = wait_sp - 16'd16;
        random_regs(sp);
        load_gprs();
        wait_mode = 1;
        a0 = ack_count;
        rf_log.delete();
        @(negedge clk);
        start = 1'b1; is_pop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(ack_count - a0 == 2 && mem_req === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) $display("FAIL rst_reach_pop3: got timeout want 3rd pop");
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL rst_abort: busy=%b req=%b want 0 0", busy, mem_req);
        else passed++;
        reset = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (rf_wr_en !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0 || rf_log.size() != 2)
            $display("FAIL rst_quiet: %0d active cycles, %0d gpr writes want 0 and 2", viol, rf_log.size());
        else passed++;
        total++;
        if (gpr[SP_IDX] !== sp) $display("FAIL rst_sp: got %h want %h", gpr[SP_IDX], sp);
        else passed++;
        wait_mode = 0;
    endtask

    task automatic test_ignored_inputs();
        int cyc, ws, d0, errs; bit to; logic [15:0] sp;
        d0 = done_count;
        @(negedge clk) ack_force = 1'b1;
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || rf_wr_en !== 1'b0)
            $display("FAIL idle_ack: busy=%b req=%b wen=%b want 0 0 0", busy, mem_req, rf_wr_en);
        else passed++;
        @(negedge clk) ack_force = 1'b0;
        total++;
        if (busy !== 1'b0 || done_count != d0) $display("FAIL idle_ack_after: busy=%b ops=%0d want 0 %0d", busy, done_count, d0);
        else passed++;
        sp = 16'($urandom);
        random_regs(sp);
        load_gprs();
        run_op(1'b0, 5, cyc, to, ws);
        @(negedge clk);
        errs = (mem_log.size() == 8) ? 0 : 1;
        for (int i = 0; i < 8 && i < mem_log.size(); i++)
            if (mem_log[i].a !== sp - 16'(2 * (i + 1)) || mem_log[i].d !== ((i == 4) ? sp : orig_regs[i])) errs++;
        total++;
        if (to || cyc != 19 || errs != 0 || done_count != d0 + 1 || busy !== 1'b0)
            $display("FAIL busy_start: cyc=%0d bad=%0d ops=%0d busy=%b want 19 0 %0d 0", cyc, errs, done_count - d0, busy, 1);
        else passed++;
    endtask

    task automatic test_random();
        int cyc, ws, errs; bit to; logic [15:0] sp;
        wait_mode = 2;
        for (int it = 0; it < 4; it++) begin
            sp = 16'($urandom);
            random_regs(sp);
            load_gprs();
            run_op(1'b0, 0, cyc, to, ws);
            errs = (mem_log.size() == 8) ? 0 : 1;
            for (int i = 0; i < 8 && i < mem_log.size(); i++)
                if (mem_log[i].a !== sp - 16'(2 * (i + 1)) || mem_log[i].d !== ((i == 4) ? sp : orig_regs[i])) errs++;
            total++;
            if (to || cyc != 19 + ws || errs != 0)
                $display("FAIL rnd_push[%0d]: cyc=%0d bad=%0d want %0d 0", it, cyc, errs, 19 + ws);
            else passed++;
            for (int i = 0; i < 8; i++) gpr_init[i] = 16'($urandom);
            gpr_init[SP_IDX] = sp - 16'd16;
            load_gprs();
            run_op(1'b1, 0, cyc, to, ws);
            errs = 0;
            for (int i = 0; i < 8; i++) if (i != 4 && gpr[i] !== orig_regs[i]) errs++;
            total++;
            if (to || cyc != 12 + ws || errs != 0 || gpr[SP_IDX] !== sp)
                $display("FAIL rnd_pop[%0d]: cyc=%0d bad=%0d sp=%h want %0d 0 %h", it, cyc, errs, gpr[SP_IDX], 12 + ws, sp);
            else passed++;
        end
        wait_mode = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_pop = 1'b0;
        test_reset();
        test_pusha_directed();
        test_popa_directed();
        test_wrap();
        test_wait_states();
        test_reset_mid_pop();
        test_ignored_inputs();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
